// File: rtl/wrr_arbiter_if.sv
// rtl/wrr_arbiter_if.sv - request/grant bundle between requester queues and the weighted round-robin arbiter
interface wrr_arbiter_if #(
    parameter int NUM_REQ  = 4,
    parameter int WEIGHT_W = 4
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]          req;
    logic [NUM_REQ*WEIGHT_W-1:0] weight;
    logic                        ack;
    logic [NUM_REQ-1:0]          gnt;
    logic                        gnt_valid;
    logic [ID_W-1:0]             gnt_id;
    logic                        gnt_last;

    modport master (
        output req, weight, ack,
        input  gnt, gnt_valid, gnt_id, gnt_last
    );

    modport slave (
        input  req, weight, ack,
        output gnt, gnt_valid, gnt_id, gnt_last
    );
endinterface

// File: rtl/wrr_arbiter.sv
// rtl/wrr_arbiter.sv - weighted round-robin arbiter with registered one-hot grant and per-grant beat budget
module wrr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WEIGHT_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    wrr_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state_q, state_n;
    logic [NUM_REQ-1:0]  gnt_q, gnt_n;
    logic [ID_W-1:0]     id_q, id_n;
    logic [WEIGHT_W-1:0] cnt_q, cnt_n;
    logic [NUM_REQ-1:0]  ptr_q, ptr_n;

    logic [ID_W-1:0]     ptr_idx;
    logic [ID_W-1:0]     base_idx;
    logic                pick_any;
    logic [ID_W-1:0]     pick_idx;
    logic [WEIGHT_W-1:0] pick_weight;
    logic [WEIGHT_W-1:0] load_cnt;
    logic                owner_req;
    logic                rel_end;
    logic                bud_end;
    logic                grant_end;
    int                  j;

    always_comb begin
        ptr_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ptr_q[i]) ptr_idx = ID_W'(i);
        end
    end

    assign owner_req = bus.req[id_q];
    assign rel_end   = (state_q == GRANT) && !owner_req;
    assign bud_end   = (state_q == GRANT) && owner_req && bus.ack && (cnt_q == WEIGHT_W'(1));
    assign grant_end = rel_end || bud_end;

    // While granting, scan from the slot after the owner so the owner ends up lowest priority;
    // this equals the rotated pointer that gets committed on grant end.
    assign base_idx = (state_q == IDLE) ? ptr_idx :
                      (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + ID_W'(1);

    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        j        = 0;
        for (int k = NUM_REQ-1; k >= 0; k--) begin
            j = int'(base_idx) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (bus.req[ID_W'(j)]) begin
                pick_any = 1'b1;
                pick_idx = ID_W'(j);
            end
        end
    end

    assign pick_weight = bus.weight[int'(pick_idx)*WEIGHT_W +: WEIGHT_W];
    assign load_cnt    = (pick_weight == '0) ? WEIGHT_W'(1) : pick_weight;

    always_comb begin
        state_n = state_q;
        gnt_n   = gnt_q;
        id_n    = id_q;
        cnt_n   = cnt_q;
        ptr_n   = ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_n = GRANT;
                    gnt_n   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    id_n    = pick_idx;
                    cnt_n   = load_cnt;
                end
            end
            GRANT: begin
                if (grant_end) begin
                    ptr_n = {gnt_q[NUM_REQ-2:0], gnt_q[NUM_REQ-1]};
                    if (pick_any) begin
                        gnt_n = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        id_n  = pick_idx;
                        cnt_n = load_cnt;
                    end else begin
                        state_n = IDLE;
                        gnt_n   = '0;
                    end
                end else if (bus.ack) begin
                    cnt_n = cnt_q - WEIGHT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            ptr_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1};
        end else begin
            state_q <= state_n;
            gnt_q   <= gnt_n;
            id_q    <= id_n;
            cnt_q   <= cnt_n;
            ptr_q   <= ptr_n;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = (state_q == GRANT);
    assign bus.gnt_id    = id_q;
    assign bus.gnt_last  = bud_end;
endmodule

// File: tb/tb_wrr_arbiter.sv
// tb/tb_wrr_arbiter.sv - vector-table and scoreboard bench for wrr_arbiter (NUM_REQ=4, WEIGHT_W=4)
module tb_wrr_arbiter;
    logic clk;
    logic rst;

    wrr_arbiter_if #(.NUM_REQ(4), .WEIGHT_W(4)) bus ();

    wrr_arbiter #(.NUM_REQ(4), .WEIGHT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] w;
        logic        ack;
        logic [3:0]  g;
        logic [1:0]  id;
        logic        last;
    } vec_t;

    typedef struct {
        logic [3:0] g;
        logic [1:0] id;
        logic       last;
        int         tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %0h expected %0h", name, tag, act, exp);
    endtask

    // Inputs go in at the falling edge; outputs are sampled 2 ns later, well before the next rising edge.
    task automatic step(input int tag, input logic r, input logic [3:0] rq, input logic [15:0] w,
                        input logic a, input logic [3:0] eg, input logic [1:0] eid, input logic el);
        exp_t e;
        @(negedge clk);
        rst        = r;
        bus.req    = rq;
        bus.weight = w;
        bus.ack    = a;
        sb.push_back('{eg, eid, el, tag});
        #2;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", tag, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("gnt",       e.tag, 32'(bus.gnt),       32'(e.g));
            chk("gnt_valid", e.tag, 32'(bus.gnt_valid), 32'(|e.g));
            chk("gnt_id",    e.tag, 32'(bus.gnt_id),    32'(e.id));
            chk("gnt_last",  e.tag, 32'(bus.gnt_last),  32'(e.last));
        end
    endtask

    initial begin
        rst        = 1'b1;
        bus.req    = 4'hF;
        bus.weight = 16'h1111;
        bus.ack    = 1'b0;
        repeat (2) @(posedge clk);

        // reset, then fairness with unit weights
        tbl.push_back('{1'b1, 4'hF, 16'h1111, 1'b0, 4'h0, 2'd0, 1'b0});
        tbl.push_back('{1'b1, 4'hF, 16'h1111, 1'b0, 4'h0, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'hF, 16'h1111, 1'b1, 4'h0, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'hF, 16'h1111, 1'b1, 4'h1, 2'd0, 1'b1});
        tbl.push_back('{1'b0, 4'hF, 16'h1111, 1'b1, 4'h2, 2'd1, 1'b1});
        tbl.push_back('{1'b0, 4'hF, 16'h1111, 1'b1, 4'h4, 2'd2, 1'b1});
        tbl.push_back('{1'b0, 4'hF, 16'h1111, 1'b1, 4'h8, 2'd3, 1'b1});
        tbl.push_back('{1'b0, 4'hF, 16'h1111, 1'b1, 4'h1, 2'd0, 1'b1});
        // weighting 3:1
        tbl.push_back('{1'b1, 4'h3, 16'h0013, 1'b0, 4'h2, 2'd1, 1'b0});
        tbl.push_back('{1'b0, 4'h3, 16'h0013, 1'b1, 4'h0, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'h3, 16'h0013, 1'b1, 4'h1, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'h3, 16'h0013, 1'b1, 4'h1, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'h3, 16'h0013, 1'b1, 4'h1, 2'd0, 1'b1});
        tbl.push_back('{1'b0, 4'h3, 16'h0013, 1'b1, 4'h2, 2'd1, 1'b1});
        tbl.push_back('{1'b0, 4'h3, 16'h0013, 1'b1, 4'h1, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'h3, 16'h0013, 1'b1, 4'h1, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'h3, 16'h0013, 1'b1, 4'h1, 2'd0, 1'b1});
        tbl.push_back('{1'b0, 4'h3, 16'h0013, 1'b1, 4'h2, 2'd1, 1'b1});
        // release by owner 2 hands over to 3 without gnt_last, then idle keeps gnt_id
        tbl.push_back('{1'b1, 4'h4, 16'h0500, 1'b0, 4'h1, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'h4, 16'h0500, 1'b0, 4'h0, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'hC, 16'h0500, 1'b1, 4'h4, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 4'h8, 16'h0500, 1'b0, 4'h4, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 4'h8, 16'h0500, 1'b0, 4'h8, 2'd3, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 16'h0500, 1'b0, 4'h8, 2'd3, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 16'h0500, 1'b0, 4'h0, 2'd3, 1'b0});
        // sole requester, weight 2: continuous grant, last every 2nd beat
        tbl.push_back('{1'b0, 4'h4, 16'h0200, 1'b1, 4'h0, 2'd3, 1'b0});
        tbl.push_back('{1'b0, 4'h4, 16'h0200, 1'b1, 4'h4, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 4'h4, 16'h0200, 1'b1, 4'h4, 2'd2, 1'b1});
        tbl.push_back('{1'b0, 4'h4, 16'h0200, 1'b1, 4'h4, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 4'h4, 16'h0200, 1'b1, 4'h4, 2'd2, 1'b1});
        tbl.push_back('{1'b0, 4'h4, 16'h0200, 1'b1, 4'h4, 2'd2, 1'b0});
        // weight 0 acts as one beat, then reset mid-grant restores pointer to requester 0
        tbl.push_back('{1'b0, 4'h6, 16'h0000, 1'b0, 4'h4, 2'd2, 1'b0});
        tbl.push_back('{1'b0, 4'h6, 16'h0000, 1'b1, 4'h4, 2'd2, 1'b1});
        tbl.push_back('{1'b0, 4'h2, 16'h0000, 1'b1, 4'h2, 2'd1, 1'b1});
        tbl.push_back('{1'b0, 4'h2, 16'h0000, 1'b0, 4'h2, 2'd1, 1'b0});
        tbl.push_back('{1'b1, 4'hF, 16'h1111, 1'b0, 4'h2, 2'd1, 1'b0});
        tbl.push_back('{1'b0, 4'hF, 16'h1111, 1'b0, 4'h0, 2'd0, 1'b0});
        tbl.push_back('{1'b0, 4'hF, 16'h1111, 1'b0, 4'h1, 2'd0, 1'b0});

        for (int i = 0; i < tbl.size(); i++)
            step(i, tbl[i].rst, tbl[i].req, tbl[i].w, tbl[i].ack, tbl[i].g, tbl[i].id, tbl[i].last);

        // max weight 15 is loaded at grant start; changing the weight mid-grant only affects the next grant
        step(100, 1'b0, 4'h1, 16'h000F, 1'b1, 4'h1, 2'd0, 1'b1);
        for (int b = 1; b <= 15; b++)
            step(100 + b, 1'b0, 4'h1, 16'h0002, 1'b1, 4'h1, 2'd0, (b == 15));
        step(116, 1'b0, 4'h1, 16'h0002, 1'b1, 4'h1, 2'd0, 1'b0);
        step(117, 1'b0, 4'h1, 16'h0002, 1'b1, 4'h1, 2'd0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
